// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RS232 receiver with runtime baud divisor, DATA_BITS 5..9,
// one or two stop bits, mid-bit start validation and a receive FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
// Handshake: rdy means the FIFO head is valid on data; a one-cycle done
// while rdy = 1 pops that head, and data shows the next entry a cycle later.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 12,
  parameter int FIFO_AW   = 3,
  parameter int STOP2     = 0
`ifdef UART_RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  input  logic [DIV_W-1:0]     div,
  input  logic                 done,
  input  logic                 clr_err,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data,
  output logic [FIFO_AW:0]     count,
  output logic                 ferr,
  output logic                 ovr,
  output logic                 perr
);

  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic                 q0, q1;
  logic [DIV_W-1:0]     divq;
  logic [DIV_W-1:0]     tick;
  logic [BW-1:0]        bitcnt;
  logic                 stopcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     wptr, rptr;

  logic bit_end, half;
  logic load, tick_clr, shift_en, stop_low, frame_end, par_bad;
  logic full, empty, pop, push;

  assign bit_end = (tick == divq - DIV_W'(1));
  assign half    = (tick == (divq >> 1));

  // Two-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0 <= 1'b1;
      q1 <= 1'b1;
    end else begin
      q0 <= RxD;
      q1 <= q0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle control strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    stop_low  = 1'b0;
    frame_end = 1'b0;
    par_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        if (q1 && !q0) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // A high sample at mid start bit is a glitch, not a frame.
        if (half) begin
          tick_clr = 1'b1;
          state_d  = q0 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_clr = 1'b1;
          shift_en = 1'b1;
          if (bitcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (bit_end) begin
          tick_clr = 1'b1;
          par_bad  = (q0 != ((^shreg) ^ 1'(PARITY_ODD)));
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tick_clr = 1'b1;
          stop_low = !q0;
          if (STOP2 == 0 || stopcnt) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, bit counters and the data shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divq    <= '0;
      tick    <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      shreg   <= '0;
    end else begin
      if (load) begin
        divq    <= div;
        tick    <= '0;
        bitcnt  <= '0;
        stopcnt <= 1'b0;
      end else if (tick_clr || state_q == IDLE) begin
        tick <= '0;
      end else begin
        tick <= tick + DIV_W'(1);
      end
      if (shift_en) begin
        shreg  <= {q0, shreg[DATA_BITS-1:1]};
        bitcnt <= bitcnt + BW'(1);
      end
      if (state_q == STOP && bit_end) stopcnt <= 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign pop   = done && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = frame_end && (!full || pop);

  // FIFO storage; contents need no reset because data is gated by rdy.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= shreg;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= (ferr && !clr_err) || stop_low;
      ovr  <= (ovr && !clr_err) || (frame_end && !push);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr <= 1'b0;
    else     perr <= (perr && !clr_err) || par_bad;
  end
`else
  assign perr = 1'b0;
`endif

  assign rdy   = !empty;
  assign data  = empty ? '0 : mem[rptr[FIFO_AW-1:0]];
  assign count = wptr - rptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (default 8N1, depth 8).
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        RxD;
  logic [11:0] div;
  logic        done;
  logic        clr_err;
  logic        rdy;
  logic [7:0]  data;
  logic [3:0]  count;
  logic        ferr, ovr, perr;
  logic        par_flip;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .RxD(RxD), .div(div), .done(done),
    .clr_err(clr_err), .rdy(rdy), .data(data), .count(count),
    .ferr(ferr), .ovr(ovr), .perr(perr)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit, data bits LSB first and (when built in) the parity bit.
  task automatic send_head(input logic [7:0] b, input int bc);
    RxD = 1'b0;
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_cyc(bc);
    end
`ifdef UART_RX_PARITY_EN
    RxD = (^b) ^ par_flip;
    wait_cyc(bc);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bc);
    send_head(b, bc);
    RxD = stop_v;
    wait_cyc(bc);
    RxD = 1'b1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    wait_cyc(1);
    done = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
  endtask

  logic [7:0] ovr_bytes [9];

  initial begin
    rst = 1'b1; RxD = 1'b1; div = 12'd217; done = 1'b0; clr_err = 1'b0; par_flip = 1'b0;
    for (int i = 0; i < 9; i++) ovr_bytes[i] = 8'(8'h11 * (i + 1));
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // Reset state.
    check("rst_rdy", rdy, 0);
    check("rst_data", data, 0);
    check("rst_count", count, 0);
    check("rst_flags", {ferr, ovr, perr}, 0);

    // Pop on empty FIFO is ignored.
    pulse_done();
    check("empty_pop_count", count, 0);

    // 0x55 at div 217; rdy must rise just after the mid stop sample.
    send_head(8'h55, 217);
    RxD = 1'b1;
    wait_cyc(100);
    check("t1_rdy_early", rdy, 0);
    wait_cyc(117);
    check("t1_rdy", rdy, 1);
    check("t1_data", data, 8'h55);
    check("t1_count", count, 1);
    check("t1_flags", {ferr, ovr, perr}, 0);

    // Back-to-back frames, then drain in order.
    send_byte(8'hA3, 1'b1, 217);
    send_byte(8'h0F, 1'b1, 217);
    send_byte(8'hFF, 1'b1, 217);
    wait_cyc(2);
    check("b2b_count", count, 4);
    check("b2b_d0", data, 8'h55); pulse_done();
    check("b2b_d1", data, 8'hA3); pulse_done();
    check("b2b_d2", data, 8'h0F); pulse_done();
    check("b2b_d3", data, 8'hFF); pulse_done();
    check("b2b_rdy_after", rdy, 0);
    check("b2b_count_after", count, 0);

    // Three-cycle low glitch is rejected; a following frame still decodes.
    RxD = 1'b0;
    wait_cyc(3);
    RxD = 1'b1;
    wait_cyc(300);
    check("glitch_count", count, 0);
    check("glitch_ferr", ferr, 0);
    div = 12'd16;
    send_byte(8'h5A, 1'b1, 16);
    wait_cyc(2);
    check("glitch_next_data", data, 8'h5A);
    check("glitch_next_count", count, 1);
    pulse_done();

    // Nine frames into a depth-8 FIFO: ninth dropped, ovr set.
    for (int i = 0; i < 9; i++) send_byte(ovr_bytes[i], 1'b1, 16);
    wait_cyc(2);
    check("ovr_count", count, 8);
    check("ovr_flag", ovr, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr_rd%0d", i), data, ovr_bytes[i]);
      pulse_done();
    end
    check("ovr_drained", rdy, 0);
    pulse_clr();
    check("ovr_cleared", ovr, 0);

    // Stop bit low: byte pushed, ferr set, then cleared.
    send_byte(8'h3C, 1'b0, 16);
    wait_cyc(16);
    check("ferr_data", data, 8'h3C);
    check("ferr_flag", ferr, 1);
    pulse_done();
    pulse_clr();
    check("ferr_cleared", ferr, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte still pushed, perr set.
    par_flip = 1'b1;
    send_byte(8'h07, 1'b1, 16);
    par_flip = 1'b0;
    wait_cyc(2);
    check("perr_flag", perr, 1);
    check("perr_data", data, 8'h07);
    pulse_done();
    pulse_clr();
    check("perr_cleared", perr, 0);
`endif

    // Break: one all-zero frame with ferr, no restart while low.
    RxD = 1'b0;
    wait_cyc(16 * 14);
    RxD = 1'b1;
    wait_cyc(40);
    check("brk_count", count, 1);
    check("brk_data", data, 0);
    check("brk_ferr", ferr, 1);

    // Reset mid data bit clears everything at once.
    RxD = 1'b0;
    wait_cyc(16);
    RxD = 1'b1;
    wait_cyc(16 * 2 + 8);
    rst = 1'b1;
    #1;
    check("mrst_outs", {rdy, data, count, ferr, ovr, perr}, 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(20);
    check("mrst_idle_count", count, 0);
    send_byte(8'h81, 1'b1, 16);
    wait_cyc(2);
    check("mrst_data", data, 8'h81);
    check("mrst_count", count, 1);
    check("mrst_ferr", ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
